// File: rtl/panel_scan_ctrl.sv
// rtl/panel_scan_ctrl.sv - HUB75 row/PWM scan sequencer; optional watchdog via PANEL_SCAN_WDOG_EN
module panel_scan_ctrl #(
  parameter int ROWS         = 32,
  parameter int PWM_LEVELS   = 16,
  parameter int LATCH_CYCLES = 2,
  parameter int SHOW_CYCLES  = 64,
  parameter int BLANK_CYCLES = 2,
  parameter int TIMEOUT      = 256
) (
  input  logic       clk_25MHz,
  input  logic       rst,
  input  logic       enable_in,
  input  logic       swap_req_in,
  output logic       swap_ack_out,
  output logic       line_begin_out,
  input  logic       line_done_in,
  output logic [4:0] row_addr_out,
  output logic [3:0] pwm_out,
  output logic       base_addr_out,
  output logic       lat_out,
  output logic       oe_n_out,
  output logic       frame_done_out,
  output logic       wdog_err_out
);

  // One shared phase counter serves every timed state, so it is sized for the longest one.
  localparam int MAX_A   = (SHOW_CYCLES > TIMEOUT) ? SHOW_CYCLES : TIMEOUT;
  localparam int MAX_B   = (LATCH_CYCLES > BLANK_CYCLES) ? LATCH_CYCLES : BLANK_CYCLES;
  localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ARM,
    S_WAIT,
    S_BLANK1,
    S_LATCH,
    S_BLANK2,
    S_SHOW,
    S_NEXT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       row_q, row_d;
  logic [3:0]       pwm_q, pwm_d;
  logic             base_q, base_d;
  logic             pend_q, pend_d;
  logic             last_pwm, last_row;

`ifdef PANEL_SCAN_WDOG_EN
  logic             wdog_q, wdog_d;
`endif

  assign last_pwm = (pwm_q == 4'(PWM_LEVELS - 1));
  assign last_row = (row_q == 5'(ROWS - 1));

  // State, step counters, buffer select and pending-swap flag.
  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      pwm_q   <= '0;
      base_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      pwm_q   <= pwm_d;
      base_q  <= base_d;
      pend_q  <= pend_d;
    end
  end

`ifdef PANEL_SCAN_WDOG_EN
  // Sticky watchdog flag, cleared only by reset.
  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      wdog_q <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`endif

  // Next-state, step advance and panel/renderer strobes.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    row_d          = row_q;
    pwm_d          = pwm_q;
    base_d         = base_q;
    pend_d         = pend_q | swap_req_in;
    line_begin_out = 1'b0;
    lat_out        = 1'b0;
    oe_n_out       = 1'b1;
    frame_done_out = 1'b0;
    swap_ack_out   = 1'b0;
`ifdef PANEL_SCAN_WDOG_EN
    wdog_d         = wdog_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (enable_in) state_d = S_START;
      end
      S_START: begin
        line_begin_out = 1'b1;
        state_d        = S_ARM;
      end
      S_ARM: begin
        // Renderer may still show a stale done here; it is not looked at.
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
`ifdef PANEL_SCAN_WDOG_EN
        if (line_done_in) begin
          cnt_d   = '0;
          state_d = S_BLANK1;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          wdog_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_BLANK1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`else
        if (line_done_in) begin
          cnt_d   = '0;
          state_d = S_BLANK1;
        end
`endif
      end
      S_BLANK1: begin
        if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_LATCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LATCH: begin
        lat_out = 1'b1;
        if (cnt_q == CNT_W'(LATCH_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_BLANK2;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BLANK2: begin
        if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_SHOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SHOW: begin
        oe_n_out = 1'b0;
        if (cnt_q == CNT_W'(SHOW_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_NEXT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_NEXT: begin
        if (!last_pwm) begin
          pwm_d = pwm_q + 1'b1;
        end else begin
          pwm_d = '0;
          if (!last_row) begin
            row_d = row_q + 1'b1;
          end else begin
            // Frame end: the only point where the buffer select may flip.
            row_d          = '0;
            frame_done_out = 1'b1;
            if (pend_d) begin
              base_d       = ~base_q;
              swap_ack_out = 1'b1;
              pend_d       = 1'b0;
            end
          end
        end
        state_d = enable_in ? S_START : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign row_addr_out  = row_q;
  assign pwm_out       = pwm_q;
  assign base_addr_out = base_q;

`ifdef PANEL_SCAN_WDOG_EN
  assign wdog_err_out = wdog_q;
`else
  assign wdog_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_panel_scan_ctrl.sv
// tb/tb_panel_scan_ctrl.sv - self-checking bench for panel_scan_ctrl (ROWS=2, PWM_LEVELS=2)
module tb_panel_scan_ctrl;
  localparam int R     = 2;
  localparam int P     = 2;
  localparam int LATW  = 2;
  localparam int SHOWW = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       swap_req = 1'b0;
  logic       line_done = 1'b1;
  logic       swap_ack_out, line_begin_out, base_addr_out, lat_out, oe_n_out;
  logic       frame_done_out, wdog_err_out;
  logic [4:0] row_addr_out;
  logic [3:0] pwm_out;

  always #20 clk = ~clk;

  panel_scan_ctrl #(
    .ROWS(R), .PWM_LEVELS(P), .LATCH_CYCLES(LATW), .SHOW_CYCLES(SHOWW),
    .BLANK_CYCLES(2), .TIMEOUT(256)
  ) dut (
    .clk_25MHz(clk), .rst(rst), .enable_in(enable), .swap_req_in(swap_req),
    .swap_ack_out(swap_ack_out), .line_begin_out(line_begin_out), .line_done_in(line_done),
    .row_addr_out(row_addr_out), .pwm_out(pwm_out), .base_addr_out(base_addr_out),
    .lat_out(lat_out), .oe_n_out(oe_n_out), .frame_done_out(frame_done_out),
    .wdog_err_out(wdog_err_out)
  );

  int total = 0, bad = 0, viol = 0, cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Renderer model: mode 0 = done drops on begin and returns rdelay clocks later,
  // mode 1 = done stuck high, mode 2 = done stuck low.
  int rmode = 0, rdelay = 100, rcnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      rcnt = 0;
      line_done = 1'b1;
    end else if (rmode == 1) begin
      line_done = 1'b1;
    end else if (rmode == 2) begin
      line_done = 1'b0;
    end else begin
      if (line_begin_out) rcnt = rdelay;
      else if (rcnt > 0) rcnt--;
      line_done = (rcnt == 0);
    end
  end

  // Reference model: step k shows (row=(k/P)%R, pwm=k%P); a frame ends every R*P steps,
  // and the buffer flips at a frame end iff any request was seen since the previous one.
  int k = 0, exp_base = 0, reqs = 0, n_begin = 0, n_ack = 0;
  int beg_len = 0, lat_len = 0, oe_len = 0;
  logic prev_oe = 1'b1, prev_lat = 1'b0, prev_base = 1'b0;
  logic [4:0] prev_row = '0;
  logic [3:0] prev_pwm = '0;
  always @(negedge clk) begin
    if (rst) begin
      k = 0; exp_base = 0; reqs = 0; beg_len = 0; lat_len = 0; oe_len = 0;
      prev_oe = 1'b1; prev_lat = 1'b0;
    end else begin
      if (swap_req) reqs++;
      if (swap_ack_out) n_ack++;
      if (lat_out && !oe_n_out) begin
        viol++;
        $display("FAIL lat_oe_overlap at cycle %0d", cyc);
      end
      if (!oe_n_out && !prev_oe &&
          (row_addr_out != prev_row || pwm_out != prev_pwm || base_addr_out != prev_base)) begin
        viol++;
        $display("FAIL addr_change_while_shown at cycle %0d", cyc);
      end
      if (line_begin_out) begin
        beg_len++;
        if (beg_len == 1) n_begin++;
      end else begin
        if (beg_len != 0) check("begin_width", beg_len, 1);
        beg_len = 0;
      end
      if (lat_out) begin
        if (!prev_lat) begin
          check("step_row", row_addr_out, (k / P) % R);
          check("step_pwm", pwm_out, k % P);
          check("step_base", base_addr_out, exp_base);
          k++;
        end
        lat_len++;
      end else if (prev_lat) begin
        check("lat_width", lat_len, LATW);
        lat_len = 0;
      end
      if (!oe_n_out) begin
        oe_len++;
      end else if (!prev_oe) begin
        check("oe_low_width", oe_len, SHOWW);
        oe_len = 0;
        check("frame_done", frame_done_out, int'(k % (R * P) == 0));
        check("swap_ack", swap_ack_out, int'((k % (R * P) == 0) && reqs > 0));
        if (k % (R * P) == 0) begin
          if (reqs > 0) exp_base ^= 1;
          reqs = 0;
        end
      end else if (frame_done_out || swap_ack_out) begin
        viol++;
        $display("FAIL stray_pulse fd=%0d ack=%0d at cycle %0d", frame_done_out, swap_ack_out, cyc);
      end
      prev_oe = oe_n_out; prev_lat = lat_out;
      prev_row = row_addr_out; prev_pwm = pwm_out; prev_base = base_addr_out;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_begin(output int c);
    c = -1;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (line_begin_out) begin
        c = cyc;
        return;
      end
    end
    check("begin_timeout", 0, 1);
  endtask

  task automatic wait_wrap();
    for (int t = 0; t < 3000; t++) begin
      if (frame_done_out) return;
      cycles(1);
    end
    check("wrap_timeout", 0, 1);
  endtask

  typedef struct {
    int mode;
    int delay;
    int exp_int;
  } vec_t;
  vec_t vecs[4];

  initial begin
    int c0, c1, c2, l0, b0, a0, base0;
    vecs[0] = '{0, 100, 172};
    vecs[1] = '{0, 2, 74};
    vecs[2] = '{0, 9, 81};
    vecs[3] = '{1, 0, 74};

    // Reset state
    cycles(3);
    check("rst_oe_n", oe_n_out, 1);
    check("rst_lat", lat_out, 0);
    check("rst_row", row_addr_out, 0);
    check("rst_pwm", pwm_out, 0);
    check("rst_base", base_addr_out, 0);
    check("rst_begin", line_begin_out, 0);
    check("rst_wdog", wdog_err_out, 0);
    rst = 1'b0;
    cycles(3);
    check("idle_oe_n", oe_n_out, 1);
    check("idle_begin", line_begin_out, 0);
    enable = 1'b1;

    // Step interval for several renderer behaviours
    foreach (vecs[i]) begin
      rmode = vecs[i].mode;
      rdelay = vecs[i].delay;
      wait_begin(c0);
      wait_begin(c1);
      wait_begin(c2);
      check($sformatf("interval%0d_a", i), c1 - c0, vecs[i].exp_int);
      check($sformatf("interval%0d_b", i), c2 - c1, vecs[i].exp_int);
    end

    // Two requests inside one frame -> one flip at the wrap
    rmode = 0; rdelay = 5;
    wait_wrap();
    cycles(20);
    swap_req = 1'b1; cycles(1); swap_req = 1'b0;
    cycles(100);
    swap_req = 1'b1; cycles(1); swap_req = 1'b0;
    a0 = n_ack; base0 = base_addr_out;
    wait_wrap();
    cycles(2);
    check("swap_once_base", base_addr_out, base0 ^ 1);
    check("swap_once_ack", n_ack - a0, 1);

    // Request arriving in the wrap cycle itself
    wait_wrap();
    a0 = n_ack; base0 = base_addr_out;
    swap_req = 1'b1; cycles(1); swap_req = 1'b0;
    cycles(2);
    check("swap_wrapcyc_base", base_addr_out, base0 ^ 1);
    check("swap_wrapcyc_ack", n_ack - a0, 1);

    // Enable drops mid-WAIT: the step still completes, then idle
    rdelay = 100;
    wait_begin(c0);
    cycles(10);
    enable = 1'b0;
    l0 = k; b0 = n_begin;
    cycles(300);
    check("stop_lat_count", k - l0, 1);
    check("stop_begin_count", n_begin - b0, 0);
    check("stop_oe_n", oe_n_out, 1);
    check("stop_lat", lat_out, 0);
    enable = 1'b1;
    wait_begin(c0);

    // Renderer never finishes
    rmode = 2;
    l0 = k;
`ifdef PANEL_SCAN_WDOG_EN
    repeat (257) @(negedge clk);
    check("wdog_before", wdog_err_out, 0);
    @(negedge clk);
    check("wdog_at_timeout", wdog_err_out, 1);
    cycles(10);
    check("wdog_scan_continues", int'(k > l0), 1);
`else
    repeat (400) @(negedge clk);
    check("nowdog_err", wdog_err_out, 0);
    check("nowdog_stuck", k - l0, 0);
`endif
    rmode = 0;

    // Random renderer delays, swap requests and enable gaps against the model
    for (int i = 0; i < 25; i++) begin
      rdelay = $urandom_range(2, 40);
      if ($urandom_range(0, 2) == 0) begin
        swap_req = 1'b1; cycles(1); swap_req = 1'b0;
      end
      if ($urandom_range(0, 4) == 0) begin
        enable = 1'b0;
        cycles($urandom_range(1, 200));
        enable = 1'b1;
      end
      wait_begin(c0);
    end

    // Asynchronous reset while the row is being shown
    for (int t = 0; t < 3000 && oe_n_out; t++) @(negedge clk);
    check("reached_show", oe_n_out, 0);
    #5 rst = 1'b1;
    #1;
    check("arst_oe_n", oe_n_out, 1);
    check("arst_lat", lat_out, 0);
    check("arst_row", row_addr_out, 0);
    check("arst_pwm", pwm_out, 0);
    check("arst_base", base_addr_out, 0);
    cycles(2);
    rst = 1'b0;
    cycles(5);

    check("invariants", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
